// File: rtl/count_chk_pkg.sv
// rtl/count_chk_pkg.sv - shared FSM state type and default constants for the count sequence checker
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int DEF_STEP   = 2;
    localparam int DEF_LOCK_N = 2;

endpackage

// File: rtl/sat_err_cnt.sv
// rtl/sat_err_cnt.sv - saturating error counter with synchronous clear
module sat_err_cnt #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [ERR_CNT_W-1:0] cnt
);

    // clear wins over the old value, but an error in the same cycle still counts as one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? ERR_CNT_W'(1) : '0;
        end else if (inc && (cnt != {ERR_CNT_W{1'b1}})) begin
            cnt <= cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - down-counter sequence checker with lock FSM; COUNT_CHK_EVEN_EN adds an even-sample check
import count_chk_pkg::*;

module count_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int STEP      = DEF_STEP,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_N    = DEF_LOCK_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 count_vld,
    input  logic                 clr,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 wrap,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     exp_count
);

    localparam int RUN_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    chk_state_t       state;
    logic [WIDTH-1:0] ref_val;
    logic [RUN_W-1:0] run_cnt;
    logic [WIDTH-1:0] nxt_exp;
    logic             sample_ok;
    logic             err_hit;

    assign nxt_exp = count_in - WIDTH'(STEP);

    // a sample is good when it continues the sequence (and is even, when enabled)
    always_comb begin
`ifdef COUNT_CHK_EVEN_EN
        sample_ok = (count_in == exp_count) && !count_in[0];
`else
        sample_ok = (count_in == exp_count);
`endif
    end

    assign err_hit = count_vld && (state == LOCKED) && !sample_ok;

    // lock FSM: every valid sample becomes the new reference; pulses last one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ref_val   <= '0;
            exp_count <= '0;
            run_cnt   <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            if (count_vld) begin
                ref_val   <= count_in;
                exp_count <= nxt_exp;
                case (state)
                    IDLE: begin
                        run_cnt <= '0;
                        state   <= SYNC;
                        locked  <= 1'b0;
                    end
                    SYNC: begin
                        if (sample_ok) begin
                            run_cnt <= run_cnt + RUN_W'(1);
                            if ((run_cnt + RUN_W'(1)) == RUN_W'(LOCK_N)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (sample_ok) begin
                            // a good sample above the old reference passed through zero
                            wrap <= (count_in > ref_val);
                        end else begin
                            mismatch <= 1'b1;
                            run_cnt  <= '0;
                            state    <= SYNC;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        run_cnt <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // sticky error flag; a new error in the clear cycle keeps it set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
        end else if (err_hit) begin
            err_sticky <= 1'b1;
        end else if (clr) begin
            err_sticky <= 1'b0;
        end
    end

    sat_err_cnt #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (err_hit),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - scoreboard bench for count_seq_checker
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = '0;
    logic       count_vld = 1'b0;
    logic       clr = 1'b0;
    logic       locked, mismatch, wrap, err_sticky;
    logic [7:0] err_cnt;
    logic [3:0] exp_count;

    logic [3:0] count_in1 = '0;
    logic       count_vld1 = 1'b0;
    logic       locked1, mismatch1, wrap1, err_sticky1;
    logic [7:0] err_cnt1;
    logic [3:0] exp_count1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       l;
        logic       m;
        logic       w;
        logic [7:0] e;
        logic       st;
        logic [3:0] x;
    } exp_t;

    exp_t sb_q[$];
    logic sample_pend = 1'b0;

    always #5 clk = ~clk;

    count_seq_checker dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .count_vld  (count_vld),
        .clr        (clr),
        .locked     (locked),
        .mismatch   (mismatch),
        .wrap       (wrap),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .exp_count  (exp_count)
    );

    count_seq_checker #(.STEP(1), .LOCK_N(1)) dut_s1 (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in1),
        .count_vld  (count_vld1),
        .clr        (clr),
        .locked     (locked1),
        .mismatch   (mismatch1),
        .wrap       (wrap1),
        .err_sticky (err_sticky1),
        .err_cnt    (err_cnt1),
        .exp_count  (exp_count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // drive one valid sample for a cycle and queue what the DUT must show afterwards
    task automatic send(input logic [3:0] s, input logic l, input logic m, input logic w,
                        input logic [7:0] e, input logic st, input logic [3:0] x);
        exp_t ex;
        ex = '{l: l, m: m, w: w, e: e, st: st, x: x};
        sb_q.push_back(ex);
        count_in  = s;
        count_vld = 1'b1;
        @(negedge clk);
        count_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        count_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) sample_pend = count_vld & rst;

    always @(negedge clk) begin
        exp_t e;
        if (sample_pend) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("locked",     {31'd0, locked},     {31'd0, e.l});
                check("mismatch",   {31'd0, mismatch},   {31'd0, e.m});
                check("wrap",       {31'd0, wrap},       {31'd0, e.w});
                check("err_cnt",    {24'd0, err_cnt},    {24'd0, e.e});
                check("err_sticky", {31'd0, err_sticky}, {31'd0, e.st});
                check("exp_count",  {28'd0, exp_count},  {28'd0, e.x});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] bad;
        logic [7:0] ec;

        #2 rst = 1'b0;
        #1;
        check("rst_locked",     {31'd0, locked},     32'd0);
        check("rst_mismatch",   {31'd0, mismatch},   32'd0);
        check("rst_wrap",       {31'd0, wrap},       32'd0);
        check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        check("rst_err_cnt",    {24'd0, err_cnt},    32'd0);
        check("rst_exp_count",  {28'd0, exp_count},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // acquire lock and run down through zero
        send(4'd0,  0, 0, 0, 8'd0, 0, 4'd14);
        send(4'd14, 0, 0, 0, 8'd0, 0, 4'd12);
        send(4'd12, 1, 0, 0, 8'd0, 0, 4'd10);
        send(4'd10, 1, 0, 0, 8'd0, 0, 4'd8);
        send(4'd8,  1, 0, 0, 8'd0, 0, 4'd6);
        idle(2);
        send(4'd6,  1, 0, 0, 8'd0, 0, 4'd4);
        send(4'd4,  1, 0, 0, 8'd0, 0, 4'd2);
        send(4'd2,  1, 0, 0, 8'd0, 0, 4'd0);
        send(4'd0,  1, 0, 0, 8'd0, 0, 4'd14);
        send(4'd14, 1, 0, 1, 8'd0, 0, 4'd12);
        idle(1);
        check("hold_wrap",      {31'd0, wrap},      32'd0);
        check("hold_locked",    {31'd0, locked},    32'd1);
        check("hold_exp_count", {28'd0, exp_count}, 32'd12);
        send(4'd12, 1, 0, 0, 8'd0, 0, 4'd10);
        send(4'd10, 1, 0, 0, 8'd0, 0, 4'd8);

        // break the sequence while locked, then relock
        send(4'd6,  0, 1, 0, 8'd1, 1, 4'd4);
        idle(1);
        check("hold_mismatch", {31'd0, mismatch}, 32'd0);
        check("hold_err_cnt",  {24'd0, err_cnt},  32'd1);
        send(4'd4,  0, 0, 0, 8'd1, 1, 4'd2);
        send(4'd2,  1, 0, 0, 8'd1, 1, 4'd0);

        // clear alone leaves the lock untouched
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_err_cnt",    {24'd0, err_cnt},    32'd0);
        check("clr_err_sticky", {31'd0, err_sticky}, 32'd0);
        check("clr_locked",     {31'd0, locked},     32'd1);
        check("clr_exp_count",  {28'd0, exp_count},  32'd0);

        // drive the error counter into saturation
        r = 4'd2;
        for (int i = 1; i <= 256; i++) begin
            bad = r - 4'd6;
            ec  = (i < 255) ? 8'(i) : 8'd255;
            send(bad,         0, 1, 0, ec, 1, bad - 4'd2);
            send(bad - 4'd2,  0, 0, 0, ec, 1, bad - 4'd4);
            send(bad - 4'd4,  1, 0, 0, ec, 1, bad - 4'd6);
            r = bad - 4'd4;
        end

        // clear coinciding with an error counts that error
        clr = 1'b1;
        send(r - 4'd6, 0, 1, 0, 8'd1, 1, r - 4'd8);
        clr = 1'b0;

        // a wrong sample in SYNC only restarts the good run
        send(4'd3,  0, 0, 0, 8'd1, 1, 4'd1);
        send(4'd10, 0, 0, 0, 8'd1, 1, 4'd8);
        send(4'd8,  0, 0, 0, 8'd1, 1, 4'd6);
        send(4'd6,  1, 0, 0, 8'd1, 1, 4'd4);

        // asynchronous reset while locked at reference 6
        #1 rst = 1'b0;
        #1;
        check("arst_locked",     {31'd0, locked},     32'd0);
        check("arst_err_sticky", {31'd0, err_sticky}, 32'd0);
        check("arst_err_cnt",    {24'd0, err_cnt},    32'd0);
        check("arst_exp_count",  {28'd0, exp_count},  32'd0);
        check("arst_mismatch",   {31'd0, mismatch},   32'd0);
        check("arst_wrap",       {31'd0, wrap},       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(4'd6, 0, 0, 0, 8'd0, 0, 4'd4);
        send(4'd4, 0, 0, 0, 8'd0, 0, 4'd2);
        send(4'd2, 1, 0, 0, 8'd0, 0, 4'd0);
        idle(2);
        check("sb_left", sb_q.size(), 32'd0);

        // STEP=1 instance: odd sample matching the step
        count_in1  = 4'd9;
        count_vld1 = 1'b1;
        @(negedge clk);
        check("s1_locked_a", {31'd0, locked1}, 32'd0);
        count_in1 = 4'd8;
        @(negedge clk);
        check("s1_locked_b", {31'd0, locked1},    32'd1);
        check("s1_exp",      {28'd0, exp_count1}, 32'd7);
        count_in1 = 4'd7;
        @(negedge clk);
        count_vld1 = 1'b0;
`ifdef COUNT_CHK_EVEN_EN
        check("s1_mismatch", {31'd0, mismatch1}, 32'd1);
        check("s1_locked_c", {31'd0, locked1},   32'd0);
`else
        check("s1_mismatch", {31'd0, mismatch1}, 32'd0);
        check("s1_locked_c", {31'd0, locked1},   32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
